// File: rtl/ysyx_22040237_mem_arb_if.sv
// IFU, LSU and memory-side handshake bundle for ysyx_22040237_mem_arb.
// slave = arbiter view; master = view of the requesters and memory around it.
`ifndef ysyx_22040237_REG_WIDTH
`define ysyx_22040237_REG_WIDTH 64
`endif

interface ysyx_22040237_mem_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = `ysyx_22040237_REG_WIDTH
);
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [ADDR_W-1:0]   ifu_req_addr;
    logic                ifu_resp_valid;
    logic [DATA_W-1:0]   ifu_resp_data;

    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic                lsu_req_wr;
    logic [ADDR_W-1:0]   lsu_req_addr;
    logic [DATA_W-1:0]   lsu_req_wdata;
    logic [DATA_W/8-1:0] lsu_req_wmask;
    logic                lsu_resp_valid;
    logic [DATA_W-1:0]   lsu_resp_data;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_wr;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [DATA_W/8-1:0] mem_req_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_valid, lsu_req_wr, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_valid, lsu_req_wr, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/ysyx_22040237_mem_arb.sv
// Shares one memory port between IFU and LSU, one transaction in flight at a time.
// Define YSYX_22040237_ARB_RR_EN for round-robin grant; default is fixed LSU priority.
//
// state  | meaning
// IDLE   | waiting for a request; the granted requester sees ready=1
// REQ    | mem_req_valid=1 with latched fields, waiting for mem_req_ready
// WAIT   | waiting for mem_resp_valid; response data captured here
// RESP   | one-cycle resp_valid to the owner of the transaction
`ifndef ysyx_22040237_REG_WIDTH
`define ysyx_22040237_REG_WIDTH 64
`endif

module ysyx_22040237_mem_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = `ysyx_22040237_REG_WIDTH
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_22040237_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t              state_q;
    state_t              state_d;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   ifu_rdata_q;
    logic [DATA_W-1:0]   lsu_rdata_q;

    logic grant_ifu;
    logic grant_lsu;
    logic accept;

`ifdef YSYX_22040237_ARB_RR_EN
    logic rr_last_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || (rr_last_q == OWN_IFU));
        grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || (rr_last_q == OWN_LSU));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= OWN_IFU;
        end else if (accept) begin
            rr_last_q <= grant_lsu ? OWN_LSU : OWN_IFU;
        end
    end
`else
    always_comb begin
        grant_lsu = bus.lsu_req_valid;
        grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
    end
`endif

    assign accept = (state_q == S_IDLE) && (grant_ifu || grant_lsu);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_REQ;
            S_REQ:   if (bus.mem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (bus.mem_resp_valid) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are frozen from accept until the next accept, so they hold through REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            if (grant_lsu) begin
                owner_q <= OWN_LSU;
                addr_q  <= bus.lsu_req_addr;
                wr_q    <= bus.lsu_req_wr;
                wdata_q <= bus.lsu_req_wdata;
                wmask_q <= bus.lsu_req_wmask;
            end else begin
                owner_q <= OWN_IFU;
                addr_q  <= bus.ifu_req_addr;
                wr_q    <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else if ((state_q == S_WAIT) && bus.mem_resp_valid) begin
            if (owner_q == OWN_LSU) begin
                lsu_rdata_q <= bus.mem_resp_data;
            end else begin
                ifu_rdata_q <= bus.mem_resp_data;
            end
        end
    end

    // Readies are gated by rst because the reset state is IDLE, where they would otherwise follow valid.
    always_comb begin
        bus.ifu_req_ready  = rst && (state_q == S_IDLE) && grant_ifu;
        bus.lsu_req_ready  = rst && (state_q == S_IDLE) && grant_lsu;
        bus.mem_req_valid  = (state_q == S_REQ);
        bus.mem_req_wr     = wr_q;
        bus.mem_req_addr   = addr_q;
        bus.mem_req_wdata  = wdata_q;
        bus.mem_req_wmask  = wmask_q;
        bus.ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
        bus.lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
        bus.ifu_resp_data  = ifu_rdata_q;
        bus.lsu_resp_data  = lsu_rdata_q;
    end

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// Bench for ysyx_22040237_mem_arb: directed scenarios then random transactions,
// each checked against a transaction-level model of grant, fields and response timing.
`timescale 1ns/1ps

module tb_ysyx_22040237_mem_arb;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int NONE = 0;
    localparam int IFU  = 1;
    localparam int LSU  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22040237_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ysyx_22040237_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int rr_last_m;
    logic [63:0] last_ifu_d;
    logic [63:0] last_lsu_d;

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    function automatic int exp_grant(input bit iv, input bit lv);
`ifdef YSYX_22040237_ARB_RR_EN
        if (iv && lv) return (rr_last_m == IFU) ? LSU : IFU;
`endif
        if (lv) return LSU;
        if (iv) return IFU;
        return NONE;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk_quiet(input string tag);
        chk(tag, "ifu_ready", bus.ifu_req_ready, 1'b0);
        chk(tag, "lsu_ready", bus.lsu_req_ready, 1'b0);
        chk(tag, "ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
        chk(tag, "lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
    endtask

    // One full transaction, entered and left at a falling edge with the arbiter idle.
    task automatic do_txn(input string tag, input bit iv, input bit lv,
                          input logic [63:0] ia, input logic [63:0] la, input bit lwr,
                          input logic [63:0] lwd, input logic [7:0] lwm,
                          input logic [63:0] rdata, input int req_wait, input int resp_wait,
                          input bit keep, input bit sp);
        int win;
        logic [63:0] e_addr, e_wd;
        logic e_wr;
        logic [7:0] e_wm;
        bus.ifu_req_valid  = iv;
        bus.ifu_req_addr   = ia;
        bus.lsu_req_valid  = lv;
        bus.lsu_req_addr   = la;
        bus.lsu_req_wr     = lwr;
        bus.lsu_req_wdata  = lwd;
        bus.lsu_req_wmask  = lwm;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        #1;
        win = exp_grant(iv, lv);
        chk(tag, "ifu_ready", bus.ifu_req_ready, win == IFU);
        chk(tag, "lsu_ready", bus.lsu_req_ready, win == LSU);
        chk(tag, "idle_mem_valid", bus.mem_req_valid, 1'b0);
        if (win == IFU) begin
            e_addr = ia; e_wr = 1'b0; e_wd = '0; e_wm = '0;
        end else begin
            e_addr = la; e_wr = lwr; e_wd = lwd; e_wm = lwm;
        end
        rr_last_m = win;
        @(negedge clk);
        if (!keep) begin
            bus.ifu_req_valid = $urandom_range(0, 1);
            bus.lsu_req_valid = $urandom_range(0, 1);
            bus.ifu_req_addr  = rnd64();
            bus.lsu_req_addr  = rnd64();
            bus.lsu_req_wr    = $urandom_range(0, 1);
            bus.lsu_req_wdata = rnd64();
            bus.lsu_req_wmask = 8'($urandom());
        end
        for (int w = 0; w <= req_wait; w++) begin
            bus.mem_req_ready  = (w == req_wait);
            bus.mem_resp_valid = sp ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_resp_data  = rnd64();
            #1;
            chk(tag, "mem_req_valid", bus.mem_req_valid, 1'b1);
            chk(tag, "mem_req_addr", bus.mem_req_addr, e_addr);
            chk(tag, "mem_req_wr", bus.mem_req_wr, e_wr);
            chk(tag, "mem_req_wdata", bus.mem_req_wdata, e_wd);
            chk(tag, "mem_req_wmask", bus.mem_req_wmask, e_wm);
            chk_quiet(tag);
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b0;
        for (int w = 0; w <= resp_wait; w++) begin
            bus.mem_resp_valid = (w == resp_wait);
            bus.mem_resp_data  = (w == resp_wait) ? rdata : rnd64();
            #1;
            chk(tag, "wait_mem_valid", bus.mem_req_valid, 1'b0);
            chk_quiet(tag);
            @(negedge clk);
        end
        bus.mem_resp_valid = sp ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_resp_data  = rnd64();
        #1;
        if (win == IFU) last_ifu_d = rdata;
        else            last_lsu_d = rdata;
        chk(tag, "ifu_resp_valid", bus.ifu_resp_valid, win == IFU);
        chk(tag, "lsu_resp_valid", bus.lsu_resp_valid, win == LSU);
        chk(tag, "ifu_resp_data", bus.ifu_resp_data, last_ifu_d);
        chk(tag, "lsu_resp_data", bus.lsu_resp_data, last_lsu_d);
        chk(tag, "resp_ifu_ready", bus.ifu_req_ready, 1'b0);
        chk(tag, "resp_lsu_ready", bus.lsu_req_ready, 1'b0);
        chk(tag, "resp_mem_valid", bus.mem_req_valid, 1'b0);
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        #1;
        chk(tag, "after_ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
        chk(tag, "after_lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
        chk(tag, "hold_ifu_resp_data", bus.ifu_resp_data, last_ifu_d);
        chk(tag, "hold_lsu_resp_data", bus.lsu_resp_data, last_lsu_d);
        chk(tag, "after_mem_valid", bus.mem_req_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_req_addr   = '0;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_req_wr     = 1'b0;
        bus.lsu_req_addr   = '0;
        bus.lsu_req_wdata  = '0;
        bus.lsu_req_wmask  = '0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        rr_last_m  = IFU;
        last_ifu_d = '0;
        last_lsu_d = '0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset with both requests pending: everything quiet and zero.
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        chk("reset", "mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("reset", "mem_req_addr", bus.mem_req_addr, 64'h0);
        chk("reset", "mem_req_wr", bus.mem_req_wr, 1'b0);
        chk("reset", "mem_req_wdata", bus.mem_req_wdata, 64'h0);
        chk("reset", "mem_req_wmask", bus.mem_req_wmask, 8'h0);
        chk("reset", "ifu_resp_data", bus.ifu_resp_data, 64'h0);
        chk("reset", "lsu_resp_data", bus.lsu_resp_data, 64'h0);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Spurious memory response while idle.
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp_data = rnd64();
            #1;
            chk_quiet("spurious_idle");
            chk("spurious_idle", "mem_req_valid", bus.mem_req_valid, 1'b0);
            chk("spurious_idle", "ifu_resp_data", bus.ifu_resp_data, 64'h0);
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;

        do_txn("ifu_read", 1'b1, 1'b0, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 8'h0,
               64'h0000_0013_DEAD_BEEF, 0, 0, 1'b0, 1'b0);
        do_txn("lsu_store", 1'b0, 1'b1, 64'h0, 64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788,
               8'hFF, 64'h0000_0000_0000_00A5, 0, 0, 1'b0, 1'b0);
        do_txn("stall", 1'b1, 1'b0, 64'h8000_0040, 64'h0, 1'b0, 64'h0, 8'h0,
               64'hCAFE_F00D_1234_5678, 5, 2, 1'b0, 1'b0);
        do_txn("tie_first", 1'b1, 1'b1, 64'h8000_0100, 64'h8000_2000, 1'b0, 64'h55, 8'h0F,
               64'h0BAD_C0DE_0000_0001, 0, 0, 1'b1, 1'b0);
        do_txn("tie_second", 1'b1, 1'b1, 64'h8000_0100, 64'h8000_2000, 1'b0, 64'h55, 8'h0F,
               64'h0BAD_C0DE_0000_0002, 0, 0, 1'b0, 1'b0);

        // Reset while waiting for the memory response aborts the transaction.
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b0;
        bus.ifu_req_addr  = 64'h8000_0200;
        #1;
        chk("rst_wait", "ifu_ready", bus.ifu_req_ready, 1'b1);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("rst_wait", "mem_req_valid", bus.mem_req_valid, 1'b1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        rr_last_m  = IFU;
        last_ifu_d = '0;
        last_lsu_d = '0;
        #1;
        chk_quiet("rst_wait_in");
        chk("rst_wait_in", "mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_wait_in", "mem_req_addr", bus.mem_req_addr, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_quiet("rst_wait_out");
            chk("rst_wait_out", "mem_req_valid", bus.mem_req_valid, 1'b0);
            chk("rst_wait_out", "ifu_resp_data", bus.ifu_resp_data, 64'h0);
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;

        // After the aborted transaction a tie must go to LSU again in either grant mode.
        do_txn("post_rst_tie", 1'b1, 1'b1, 64'h8000_0300, 64'h8000_3000, 1'b1, 64'h77, 8'h3C,
               64'h1357_9BDF_2468_ACE0, 1, 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit iv, lv;
            iv = $urandom_range(0, 1);
            lv = $urandom_range(0, 1);
            if (!iv && !lv) begin
                if ($urandom_range(0, 1) == 0) iv = 1'b1;
                else                           lv = 1'b1;
            end
            do_txn("random", iv, lv, rnd64(), rnd64(), 1'($urandom_range(0, 1)), rnd64(),
                   8'($urandom()), rnd64(), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
